fht_in_mix_pipe: RTL and testbench
==================================

FHT_IN_MIX_PIPE -- requirements
Module: fht_in_mix_pipe

Interface
REQ-001 Parameter D_BIT, default 17, sample width in bits (two's complement).
REQ-002 Parameter SEC_BIT, default 9, width of the sector index.
REQ-003 Parameter LANES, default 1, number of independent 4-bank butterfly lanes; bank count is 4*LANES.
REQ-004 iCLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 iRESET  in  1  asynchronous, active-low reset.
REQ-006 iVALID  in  1  input beat valid.
REQ-007 oREADY  out  1  block can accept an input beat.
REQ-008 iST_ZERO  in  1  first-stage (zero) routing mode for this beat.
REQ-009 iSECTOR  in  SEC_BIT  sector index for this beat.
REQ-010 iINV  in  1  inverse-transform mode: negate sine-path output.
REQ-011 iBANK  in  4*LANES*D_BIT  bank words; lane l bank b at bits [(4l+b)*D_BIT +: D_BIT].
REQ-012 oVALID  out  1  output beat valid.
REQ-013 iREADY  in  1  downstream accepts output beat.
REQ-014 oY_0 / oY_1 / oY_2  out  LANES*D_BIT each  sum, cosine-multiplier and sine-multiplier operands; lane l at [l*D_BIT +: D_BIT].
REQ-015 oSECTOR  out  SEC_BIT  sector index carried alongside the output beat.
REQ-016 oSAT  out  1  sticky flag: a negation saturated since reset.

Function
REQ-017 Input beat accepted on a cycle where iVALID=1 and oREADY=1; output beat transferred where oVALID=1 and iREADY=1.
REQ-018 Routing per lane (B0..B3 = that lane's banks), evaluated on accepted beat; first matching row applies:
- iST_ZERO=1: Y0=B0, Y1=B1, Y2=0.
- sector 0: Y0=B0, Y1=B1, Y2=B1.
- sector 1: Y0=B1, Y1=B0, Y2=B2.
- sector >=2 odd: Y0=B0, Y1=B1, Y2=B2.
- sector >=2 even: Y0=B1, Y1=B0, Y2=B3.
REQ-019 When iINV=1, Y2 is replaced by its two's-complement negation; -2^(D_BIT-1) saturates to 2^(D_BIT-1)-1 and sets oSAT; Y2=0 in zero mode stays 0; Y0/Y1 never negated.
REQ-020 Latency: accepted beat appears on outputs the next cycle (1 cycle) when the output register is empty or draining.
REQ-021 Storage: one output register plus one skid register, each holding routed Y0..Y2, sector and a valid bit.
REQ-022 oREADY is driven directly from a flop: oREADY = skid register empty.
REQ-023 Output register loads when empty or transferring this cycle: from skid if skid full, else from accepted input.
REQ-024 Input accepted while output register is held (oVALID=1, iREADY=0) goes into the skid register; oREADY deasserts the following cycle.
REQ-025 Simultaneous accept and transfer with skid empty: output register takes the new beat, oVALID stays 1, no bubble.
REQ-026 Beats leave in acceptance order; none dropped or duplicated; output contents are stable while oVALID=1 and iREADY=0.
REQ-027 States: EMPTY (oVALID=0), ONE (output full, skid empty), TWO (both full, oREADY=0); transitions only via REQ-023..025.
REQ-028 Full throughput: with iVALID=iREADY=1 every cycle, one beat per cycle.
REQ-029 Lanes share control and sector; lane routing is independent of LANES.

Reset
REQ-030 iRESET low asynchronously clears: oVALID=0, both valid bits 0, oY_0/1/2=0, oSECTOR=0, oSAT=0, oREADY=0 while asserted.
REQ-031 oREADY=1 from the first clock edge after iRESET deasserts; a beat in flight at reset is discarded.

Verification
REQ-032 Zero mode, LANES=1, D_BIT=17: banks 5,6,7,8, iST_ZERO=1, iINV=0 -> next cycle Y0=5, Y1=6, Y2=0, oVALID=1.
REQ-033 Sector sweep 0,1,2,3 with banks 5,6,7,8 -> (5,6,6), (6,5,7), (6,5,8), (5,6,7).
REQ-034 iINV=1, sector 3, B2=-65536 -> Y2=65535, oSAT=1 and stays 1; B2=100 -> Y2=-100.
REQ-035 Backpressure: stream 10 beats, iREADY low cycles 3-5 -> oREADY low one cycle later, all 10 beats out in order, output held stable while stalled.
REQ-036 LANES=2: lane 1 banks 9,10,11,12, sector 2 -> lane 1 Y = (10,9,12), independent of lane 0.
REQ-037 Reset asserted in state TWO -> oVALID=0 and outputs 0 immediately; after release, oREADY=1 and no stale beat emitted.

Source files
------------

// File: rtl/fht_in_mix_pipe.sv
// fht_in_mix_pipe: input mixing stage of the FHT butterfly.
// Routes each lane's four bank words onto the sum / cosine / sine operand
// ports according to sector and zero-stage mode. Optionally negates the
// sine-path operand with saturation. The result sits in a one-deep output
// register backed by a skid register, so oREADY comes straight from a flop.
module fht_in_mix_pipe #(
  parameter int D_BIT   = 17,
  parameter int SEC_BIT = 9,
  parameter int LANES   = 1
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iVALID,
  output logic                     oREADY,
  input  logic                     iST_ZERO,
  input  logic [SEC_BIT-1:0]       iSECTOR,
  input  logic                     iINV,
  input  logic [4*LANES*D_BIT-1:0] iBANK,
  output logic                     oVALID,
  input  logic                     iREADY,
  output logic [LANES*D_BIT-1:0]   oY_0,
  output logic [LANES*D_BIT-1:0]   oY_1,
  output logic [LANES*D_BIT-1:0]   oY_2,
  output logic [SEC_BIT-1:0]       oSECTOR,
  output logic                     oSAT
);

  localparam int LW = LANES * D_BIT;
  localparam logic [D_BIT-1:0] S_MIN = {1'b1, {(D_BIT-1){1'b0}}};
  localparam logic [D_BIT-1:0] S_MAX = {1'b0, {(D_BIT-1){1'b1}}};

  typedef struct packed {
    logic [LW-1:0]      y0;
    logic [LW-1:0]      y1;
    logic [LW-1:0]      y2;
    logic [SEC_BIT-1:0] sec;
  } beat_t;

  beat_t in_beat;
  beat_t out_q;
  beat_t skid_q;
  logic  in_sat;
  logic  out_vld;
  logic  skid_vld;
  logic  rdy_q;
  logic  sat_q;
  logic  accept;
  logic  load;

  // Route every lane's banks for the beat currently presented on the inputs.
  always_comb begin
    logic [D_BIT-1:0] b0, b1, b2, b3, y2;
    // NOTE: every variable gets a default first so no path infers a latch.
    in_beat     = '0;
    in_sat      = 1'b0;
    b0          = '0;
    b1          = '0;
    b2          = '0;
    b3          = '0;
    y2          = '0;
    in_beat.sec = iSECTOR;
    for (int l = 0; l < LANES; l++) begin
      b0 = iBANK[(4*l+0)*D_BIT +: D_BIT];
      b1 = iBANK[(4*l+1)*D_BIT +: D_BIT];
      b2 = iBANK[(4*l+2)*D_BIT +: D_BIT];
      b3 = iBANK[(4*l+3)*D_BIT +: D_BIT];
      if (iST_ZERO) begin
        in_beat.y0[l*D_BIT +: D_BIT] = b0;
        in_beat.y1[l*D_BIT +: D_BIT] = b1;
        y2 = '0;
      end else if (iSECTOR == SEC_BIT'(0)) begin
        in_beat.y0[l*D_BIT +: D_BIT] = b0;
        in_beat.y1[l*D_BIT +: D_BIT] = b1;
        y2 = b1;
      end else if (iSECTOR == SEC_BIT'(1)) begin
        in_beat.y0[l*D_BIT +: D_BIT] = b1;
        in_beat.y1[l*D_BIT +: D_BIT] = b0;
        y2 = b2;
      end else if (iSECTOR[0]) begin
        in_beat.y0[l*D_BIT +: D_BIT] = b0;
        in_beat.y1[l*D_BIT +: D_BIT] = b1;
        y2 = b2;
      end else begin
        in_beat.y0[l*D_BIT +: D_BIT] = b1;
        in_beat.y1[l*D_BIT +: D_BIT] = b0;
        y2 = b3;
      end
      // Zero-mode Y2 is already 0, and negating 0 leaves it 0 without saturating.
      if (iINV) begin
        if (y2 == S_MIN) begin
          y2     = S_MAX;
          in_sat = 1'b1;
        end else begin
          y2 = -y2;
        end
      end
      in_beat.y2[l*D_BIT +: D_BIT] = y2;
    end
  end

  assign accept = iVALID & rdy_q;
  assign load   = ~out_vld | iREADY;

  // Output/skid register pair: the skid catches a beat accepted while the output is held.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      // NOTE: data registers are cleared too because the outputs must read 0 during reset.
      out_q    <= '0;
      skid_q   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (load) begin
        if (skid_vld) begin
          out_q   <= skid_q;
          out_vld <= 1'b1;
        end else begin
          out_vld <= accept;
          if (accept) out_q <= in_beat;
        end
      end
      if (skid_vld && load) begin
        skid_vld <= 1'b0;
      end else if (accept && !load) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
      end
      rdy_q <= ~((skid_vld | accept) & ~load);
      if (accept && in_sat) sat_q <= 1'b1;
    end
  end

  assign oREADY  = rdy_q;
  assign oVALID  = out_vld;
  assign oY_0    = out_q.y0;
  assign oY_1    = out_q.y1;
  assign oY_2    = out_q.y2;
  assign oSECTOR = out_q.sec;
  assign oSAT    = sat_q;

endmodule

// File: tb/tb_fht_in_mix_pipe.sv
// Self-checking bench for fht_in_mix_pipe (two lanes, 17-bit samples).
// Expected beats come from a routing-table model and flow through a FIFO
// scoreboard; the occupancy of that FIFO predicts oVALID and oREADY.
module tb_fht_in_mix_pipe;

  localparam int D    = 17;
  localparam int S    = 9;
  localparam int L    = 2;
  localparam int W    = L * D;
  localparam int BW   = 4 * L * D;
  localparam int MAXV = (1 << (D - 1)) - 1;

  typedef struct {
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [S-1:0] sec;
    logic         sat;
  } exp_t;

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic          iVALID;
  logic          oREADY;
  logic          iST_ZERO;
  logic [S-1:0]  iSECTOR;
  logic          iINV;
  logic [BW-1:0] iBANK;
  logic          oVALID;
  logic          iREADY;
  logic [W-1:0]  oY_0;
  logic [W-1:0]  oY_1;
  logic [W-1:0]  oY_2;
  logic [S-1:0]  oSECTOR;
  logic          oSAT;

  exp_t q[$];
  logic exp_sat;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  fht_in_mix_pipe #(.D_BIT(D), .SEC_BIT(S), .LANES(L)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(oREADY),
    .iST_ZERO(iST_ZERO), .iSECTOR(iSECTOR), .iINV(iINV), .iBANK(iBANK),
    .oVALID(oVALID), .iREADY(iREADY), .oY_0(oY_0), .oY_1(oY_1), .oY_2(oY_2),
    .oSECTOR(oSECTOR), .oSAT(oSAT)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Pack lane 0 banks a0..a3 and lane 1 banks c0..c3 (low D bits of each int).
  function automatic logic [BW-1:0] pk(input int a0, a1, a2, a3, c0, c1, c2, c3);
    int v[8];
    int t;
    logic [BW-1:0] r;
    v = '{a0, a1, a2, a3, c0, c1, c2, c3};
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = v[i];
      r[i*D +: D] = t[D-1:0];
    end
    return r;
  endfunction

  // Reference routing: table lookup on signed integers, negation clamped to MAXV.
  function automatic exp_t model(input logic z, input logic [S-1:0] sec,
                                 input logic inv, input logic [BW-1:0] bank);
    exp_t r;
    logic signed [D-1:0] s;
    int b[4];
    int y0, y1, y2, sv;
    r.y0 = '0; r.y1 = '0; r.y2 = '0; r.sec = sec; r.sat = 1'b0;
    sv = int'(sec);
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < 4; i++) begin
        s = bank[(4*l+i)*D +: D];
        b[i] = s;
      end
      if (z)                  begin y0 = b[0]; y1 = b[1]; y2 = 0;    end
      else if (sv == 0)       begin y0 = b[0]; y1 = b[1]; y2 = b[1]; end
      else if (sv == 1)       begin y0 = b[1]; y1 = b[0]; y2 = b[2]; end
      else if (sv % 2 == 1)   begin y0 = b[0]; y1 = b[1]; y2 = b[2]; end
      else                    begin y0 = b[1]; y1 = b[0]; y2 = b[3]; end
      if (inv && !z) begin
        y2 = -y2;
        if (y2 > MAXV) begin
          y2 = MAXV;
          r.sat = 1'b1;
        end
      end
      r.y0[l*D +: D] = y0[D-1:0];
      r.y1[l*D +: D] = y1[D-1:0];
      r.y2[l*D +: D] = y2[D-1:0];
    end
    return r;
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic v, input logic z, input logic [S-1:0] sec, input logic inv,
                      input logic [BW-1:0] bank, input logic rdy, output logic acc);
    logic xfer;
    exp_t e;
    check("ovalid", oVALID, q.size() > 0);
    check("oready", oREADY, q.size() < 2);
    check("osat", oSAT, exp_sat);
    if (oVALID && q.size() > 0) begin
      check("y0", oY_0, q[0].y0);
      check("y1", oY_1, q[0].y1);
      check("y2", oY_2, q[0].y2);
      check("sector", oSECTOR, q[0].sec);
    end
    iVALID = v; iST_ZERO = z; iSECTOR = sec; iINV = inv; iBANK = bank; iREADY = rdy;
    acc  = v && (q.size() < 2);
    xfer = (q.size() > 0) && rdy;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      e = model(z, sec, inv, bank);
      q.push_back(e);
      exp_sat = exp_sat | e.sat;
    end
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, acc);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic          acc;
    logic [BW-1:0] bank;
    int            k, cyc;

    exp_sat = 1'b0;
    iRESET = 1'b0; iVALID = 1'b0; iST_ZERO = 1'b0; iSECTOR = '0;
    iINV = 1'b0; iBANK = '0; iREADY = 1'b0;
    #1;
    check("rst_ovalid", oVALID, 0);
    check("rst_oready", oREADY, 0);
    check("rst_y0", oY_0, 0);
    check("rst_osat", oSAT, 0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRESET = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);

    // Zero-stage routing, held on the output.
    bank = pk(5, 6, 7, 8, 9, 10, 11, 12);
    step(1'b1, 1'b1, 9'd0, 1'b0, bank, 1'b0, acc);
    check("zero_valid", oVALID, 1);
    check("zero_y0", oY_0[D-1:0], 5);
    check("zero_y1", oY_1[D-1:0], 6);
    check("zero_y2", oY_2[D-1:0], 0);

    // Sector sweep 0..3 at full rate.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 1'b0, S'(s), 1'b0, bank, 1'b1, acc);
      if (s == 2) begin
        check("lane1_y0", oY_0[D +: D], 10);
        check("lane1_y1", oY_1[D +: D], 9);
        check("lane1_y2", oY_2[D +: D], 12);
      end
    end
    drain();

    // Inverse mode: saturating negation, then an ordinary one.
    step(1'b1, 1'b0, 9'd3, 1'b1, pk(0, 0, -65536, 0, 1, 2, 3, 4), 1'b1, acc);
    check("inv_sat_y2", oY_2[D-1:0], 17'h0FFFF);
    check("inv_sat_flag", oSAT, 1);
    step(1'b1, 1'b0, 9'd3, 1'b1, pk(0, 0, 100, 0, 1, 2, 3, 4), 1'b1, acc);
    check("inv_neg_y2", oY_2[D-1:0], 17'h1FF9C);
    check("inv_sat_sticky", oSAT, 1);
    drain();

    // Backpressure: 10 beats, downstream stalled on cycles 3..5.
    k = 0;
    cyc = 0;
    while ((k < 10 || q.size() > 0) && cyc < 60) begin
      step(k < 10, 1'b0, S'(k), 1'b0, pk(k+1, k+2, k+3, k+4, k+5, k+6, k+7, k+8),
           !(cyc >= 3 && cyc <= 5), acc);
      if (acc) k++;
      cyc++;
    end
    check("bp_all_accepted", k, 10);
    check("bp_all_out", q.size(), 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++)
        bank[i*D +: D] = ($urandom_range(0, 9) == 0) ? 17'h10000 : D'($urandom);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 1) == 1) ? S'($urandom_range(0, 3)) : S'($urandom),
           $urandom_range(0, 1) == 1, bank, $urandom_range(0, 9) < 7, acc);
    end
    drain();

    // Fill both registers, then reset asynchronously between clock edges.
    step(1'b1, 1'b0, 9'd3, 1'b1, pk(0, 0, -65536, 0, 1, 2, 3, 4), 1'b0, acc);
    step(1'b1, 1'b0, 9'd2, 1'b0, bank, 1'b0, acc);
    check("two_oready", oREADY, 0);
    iVALID = 1'b0;
    #2 iRESET = 1'b0;
    #1;
    check("arst_ovalid", oVALID, 0);
    check("arst_oready", oREADY, 0);
    check("arst_y0", oY_0, 0);
    check("arst_y1", oY_1, 0);
    check("arst_y2", oY_2, 0);
    check("arst_sector", oSECTOR, 0);
    check("arst_osat", oSAT, 0);
    q.delete();
    exp_sat = 1'b0;
    #1 iRESET = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, acc);
    step(1'b1, 1'b0, 9'd1, 1'b0, bank, 1'b1, acc);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
